mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Arbitrates the write port and the read port of a simple dual-port RAM among several write and read requesters. The RAM has one write port and one registered read port with a one-cycle read latency. The scheduler zero-initialises the whole RAM after reset, then grants each port round-robin. It returns tagged read responses one cycle after grant and forwards write data when a read and a write hit the same address in the same cycle. It sits between the coherence-side requesters and the RAM macro, and is the RAM's only master.

## Interface
- addr_width, default 6: RAM address width; depth is 2^addr_width.
- data_width, default 64: RAM word width.
- n_wr, default 2: number of write requesters (≥1).
- n_rd, default 2: number of read requesters (≥1).

- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- wr_req_valid  in  n_wr  per-requester write request.
- wr_req_addr  in  n_wr*addr_width  packed; requester i occupies slice [i*addr_width +: addr_width].
- wr_req_data  in  n_wr*data_width  packed, same slicing rule.
- wr_req_ready  out  n_wr  one-hot grant; a transfer occurs when valid & ready.
- rd_req_valid  in  n_rd  per-requester read request.
- rd_req_addr  in  n_rd*addr_width  packed.
- rd_req_ready  out  n_rd  one-hot grant.
- rd_resp_valid  out  n_rd  one-hot; response for requester i.
- rd_resp_data  out  data_width  shared response data; meaningful only while some rd_resp_valid bit is set.
- init_done  out  1  high once the zero sweep has completed.
- ram_wen  out  1  RAM write enable.
- ram_waddr  out  addr_width  RAM write address.
- ram_din  out  data_width  RAM write data.
- ram_ren  out  1  RAM read enable.
- ram_raddr  out  addr_width  RAM read address.
- ram_dout  in  data_width  RAM registered read data; value at cycle t+1 is mem[ram_raddr at t], sampled before any write at t.

## Operation
- FSM has two states, INIT and RUN. Reset forces INIT.
- **INIT**
  - A sweep counter starts at 0. Each cycle: ram_wen=1, ram_waddr=counter, ram_din=0.
  - After the write to address 2^addr_width−1, the FSM goes to RUN.
  - All ready and resp_valid outputs are 0; ram_ren=0.
- **RUN**
  - init_done=1.
  - Write port: round-robin among asserted wr_req_valid bits. Search starts at pointer wr_ptr and wraps modulo n_wr.
  - On a grant to requester g: wr_req_ready[g]=1 (combinational in the same cycle), ram_wen=1, ram_waddr and ram_din taken from slice g. Then wr_ptr ← (g+1) mod n_wr.
  - With no write request: ram_wen=0 and wr_ptr is unchanged.
  - Read port: identical round-robin with rd_ptr. A grant drives ram_ren=1 and ram_raddr from the granted slice.
  - A read grant at cycle t registers the granted index, and rd_resp_valid[index]=1 at t+1 for exactly one cycle. There is no response backpressure; requesters must accept the response.
  - Same-cycle collision: a read grant and a write grant in the same cycle with equal addresses sets a bypass flag and registers the write data. At t+1, rd_resp_data is the registered write data instead of ram_dout.
  - Otherwise rd_resp_data = ram_dout.
  - Reads and writes to different addresses proceed in parallel, so up to one read and one write are granted per cycle.
- Requesters hold valid, addr and data stable until granted. The scheduler does not rely on this for correctness.

## Timing
- **Reset values** (applied at a clock edge with reset=0):
  - FSM=INIT, sweep counter=0, wr_ptr=rd_ptr=0, init_done=0, rd_resp_valid=0.
  - Bypass flag=0, response index register=0.
  - Ready outputs, ram_wen and ram_ren are gated by FSM state. In the first INIT cycle ram_wen=1 and ram_waddr=0.
- **INIT length:** 2^addr_width cycles. init_done rises in the first RUN cycle.
- **Handshake timing:** ready is combinational from valid, pointer and state, with no request-to-grant latency. Read latency from grant to response is exactly 1 cycle. Sustained throughput is 1 read and 1 write per cycle.
- **Write visibility:** a write granted at t is visible to any read granted at t+1 or later through the RAM itself. A read at t sees it through the bypass path.
- **Reset mid-operation:**
  - A response scheduled for the next cycle is dropped: rd_resp_valid=0.
  - Pointers clear and the sweep restarts at address 0.
- **Single requester:** n_wr=1 or n_rd=1 degenerates to a pass-through grant, with the pointer held at 0.

## Test plan
- Reset, then hold reset=1 (addr_width=6) → ram_wen high with ram_waddr 0..63 over 64 cycles and ram_din=0. init_done=1 at cycle 64. No ready asserted before then.
- In RUN, wr0 writes 0xA5 to addr 3, then rd1 reads addr 3 two cycles later → rd_req_ready[1] in the grant cycle, then rd_resp_valid=2'b10 with rd_resp_data=0xA5 one cycle later.
- Both writers hold valid continuously (addrs 1 and 2) → grants alternate wr0, wr1, wr0, wr1. Both readers continuously → alternating grants, with each response index matching the grant of the prior cycle.
- Same cycle: wr0 writes 0x1234 to addr 7 while rd0 reads addr 7 (old content 0) → response data is 0x1234, not 0. With a different read addr 8 → response is mem[8].
- Read of a never-written address after INIT → data 0.
- Reset asserted the cycle after a read grant → rd_resp_valid stays 0. init_done drops, the sweep restarts at address 0, and after release the first grant goes to requester 0.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler for one write port and one registered read port of a dual-port RAM.
// Zero-sweeps the RAM after reset and forwards same-cycle write data to colliding reads.
module mem_port_scheduler #(
    parameter int addr_width = 6,
    parameter int data_width = 64,
    parameter int n_wr       = 2,
    parameter int n_rd       = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [n_wr-1:0]            wr_req_valid,
    input  logic [n_wr*addr_width-1:0] wr_req_addr,
    input  logic [n_wr*data_width-1:0] wr_req_data,
    output logic [n_wr-1:0]            wr_req_ready,
    input  logic [n_rd-1:0]            rd_req_valid,
    input  logic [n_rd*addr_width-1:0] rd_req_addr,
    output logic [n_rd-1:0]            rd_req_ready,
    output logic [n_rd-1:0]            rd_resp_valid,
    output logic [data_width-1:0]      rd_resp_data,
    output logic                       init_done,
    output logic                       ram_wen,
    output logic [addr_width-1:0]      ram_waddr,
    output logic [data_width-1:0]      ram_din,
    output logic                       ram_ren,
    output logic [addr_width-1:0]      ram_raddr,
    input  logic [data_width-1:0]      ram_dout
);
    localparam int WPW = (n_wr > 1) ? $clog2(n_wr) : 1;
    localparam int RPW = (n_rd > 1) ? $clog2(n_rd) : 1;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state;
    logic [addr_width-1:0] sweep;
    logic [WPW-1:0]        wr_ptr, wr_idx;
    logic [RPW-1:0]        rd_ptr, rd_idx, resp_idx;
    logic                  wr_found, rd_found, wr_gnt, rd_gnt;
    logic                  resp_pend, bypass;
    logic [data_width-1:0] byp_data;
    logic [addr_width-1:0] wr_addr, rd_addr;
    logic [data_width-1:0] wr_data;

    // Walk from the far end back towards the pointer so the closest requester wins.
    always_comb begin
        wr_found = 1'b0;
        wr_idx   = '0;
        for (int k = n_wr - 1; k >= 0; k--) begin
            if (wr_req_valid[WPW'((int'(wr_ptr) + k) % n_wr)]) begin
                wr_found = 1'b1;
                wr_idx   = WPW'((int'(wr_ptr) + k) % n_wr);
            end
        end
    end

    always_comb begin
        rd_found = 1'b0;
        rd_idx   = '0;
        for (int k = n_rd - 1; k >= 0; k--) begin
            if (rd_req_valid[RPW'((int'(rd_ptr) + k) % n_rd)]) begin
                rd_found = 1'b1;
                rd_idx   = RPW'((int'(rd_ptr) + k) % n_rd);
            end
        end
    end

    assign wr_gnt  = (state == RUN) && wr_found;
    assign rd_gnt  = (state == RUN) && rd_found;
    assign wr_addr = wr_req_addr[wr_idx*addr_width +: addr_width];
    assign wr_data = wr_req_data[wr_idx*data_width +: data_width];
    assign rd_addr = rd_req_addr[rd_idx*addr_width +: addr_width];

    always_comb begin
        wr_req_ready  = '0;
        rd_req_ready  = '0;
        rd_resp_valid = '0;
        if (wr_gnt) wr_req_ready[wr_idx] = 1'b1;
        if (rd_gnt) rd_req_ready[rd_idx] = 1'b1;
        if (resp_pend) rd_resp_valid[resp_idx] = 1'b1;
    end

    always_comb begin
        if (state == INIT) begin
            ram_wen   = 1'b1;
            ram_waddr = sweep;
            ram_din   = '0;
        end else begin
            ram_wen   = wr_gnt;
            ram_waddr = wr_gnt ? wr_addr : '0;
            ram_din   = wr_gnt ? wr_data : '0;
        end
    end

    assign ram_ren      = rd_gnt;
    assign ram_raddr    = rd_gnt ? rd_addr : '0;
    assign init_done    = (state == RUN);
    assign rd_resp_data = bypass ? byp_data : ram_dout;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= INIT;
            sweep     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            resp_pend <= 1'b0;
            resp_idx  <= '0;
            bypass    <= 1'b0;
            byp_data  <= '0;
        end else begin
            if (state == INIT) begin
                sweep <= sweep + 1'b1;
                if (sweep == {addr_width{1'b1}}) state <= RUN;
            end
            if (wr_gnt) wr_ptr <= (int'(wr_idx) + 1 >= n_wr) ? '0 : wr_idx + 1'b1;
            if (rd_gnt) begin
                rd_ptr   <= (int'(rd_idx) + 1 >= n_rd) ? '0 : rd_idx + 1'b1;
                resp_idx <= rd_idx;
            end
            resp_pend <= rd_gnt;
            // The RAM returns pre-write data on a same-address collision, so carry the new word.
            bypass    <= rd_gnt && wr_gnt && (rd_addr == wr_addr);
            byp_data  <= wr_data;
        end
    end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench: a behavioural RAM plus a round-robin reference model checked every cycle.
module tb_mem_port_scheduler;
    localparam int AW = 6;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    wr_req_valid, wr_req_ready;
    logic [2*AW-1:0] wr_req_addr;
    logic [2*DW-1:0] wr_req_data;
    logic [1:0]    rd_req_valid, rd_req_ready, rd_resp_valid;
    logic [2*AW-1:0] rd_req_addr;
    logic [DW-1:0] rd_resp_data;
    logic          init_done, ram_wen, ram_ren;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_din, ram_dout;

    mem_port_scheduler #(.addr_width(AW), .data_width(DW), .n_wr(2), .n_rd(2)) dut (
        .clock(clock), .reset(reset),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_ready(wr_req_ready),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .init_done(init_done),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_din(ram_din),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [64];
    always @(posedge clock) begin
        if (ram_ren) ram_dout <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_din;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rr(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            int i = (p + k) % 2;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct { int idx; logic [DW-1:0] data; } resp_t;
    resp_t q[$];
    logic [DW-1:0] shadow [64];
    bit m_run = 0;
    int m_cnt = 0, m_wptr = 0, m_rptr = 0;

    always @(negedge clock) begin
        resp_t e;
        logic [1:0] exp_rv, exp_wr, exp_rr;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        int wg, rg;
        exp_rv = '0;
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_rv[e.idx] = 1'b1;
        end
        chk("resp_valid", rd_resp_valid, exp_rv);
        if (exp_rv != 0) chk("resp_data", rd_resp_data, e.data);
        chk("init_done", init_done, m_run);
        if (!m_run) begin
            chk("init_wen", ram_wen, 1);
            chk("init_waddr", ram_waddr, m_cnt);
            chk("init_din", ram_din, 0);
            chk("init_wr_ready", wr_req_ready, 0);
            chk("init_rd_ready", rd_req_ready, 0);
            chk("init_ren", ram_ren, 0);
            if (reset) begin
                if (m_cnt == 63) m_run = 1;
                m_cnt++;
            end
        end else begin
            wg = rr(wr_req_valid, m_wptr);
            rg = rr(rd_req_valid, m_rptr);
            exp_wr = '0; exp_rr = '0;
            if (wg >= 0) exp_wr[wg] = 1'b1;
            if (rg >= 0) exp_rr[rg] = 1'b1;
            chk("wr_ready", wr_req_ready, exp_wr);
            chk("rd_ready", rd_req_ready, exp_rr);
            chk("ram_wen", ram_wen, wg >= 0);
            chk("ram_ren", ram_ren, rg >= 0);
            wa = '0; wd = '0;
            if (wg >= 0) begin
                wa = wr_req_addr[wg*AW +: AW];
                wd = wr_req_data[wg*DW +: DW];
                chk("ram_waddr", ram_waddr, wa);
                chk("ram_din", ram_din, wd);
            end
            if (rg >= 0) begin
                ra = rd_req_addr[rg*AW +: AW];
                chk("ram_raddr", ram_raddr, ra);
                e.idx  = rg;
                e.data = (wg >= 0 && wa == ra) ? wd : shadow[ra];
                q.push_back(e);
                m_rptr = (rg + 1) % 2;
            end
            if (wg >= 0) begin
                shadow[wa] = wd;
                m_wptr = (wg + 1) % 2;
            end
        end
        if (!reset) begin
            q.delete();
            m_run = 0; m_cnt = 0; m_wptr = 0; m_rptr = 0;
            for (int i = 0; i < 64; i++) shadow[i] = '0;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_req_valid = '0;
        rd_req_valid = '0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 200) begin
            cyc();
            n++;
        end
        chk("init_timeout", init_done, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        reset = 1'b0;
        idle();
        wr_req_addr = '0; wr_req_data = '0; rd_req_addr = '0;
        repeat (3) cyc();
        reset = 1'b1;
        wait_init();

        // single write then a delayed read through requester 1
        wr_req_valid = 2'b01; wr_req_addr[0 +: AW] = 6'd3; wr_req_data[0 +: DW] = 64'hA5;
        cyc(); idle(); cyc();
        rd_req_valid = 2'b10; rd_req_addr[AW +: AW] = 6'd3;
        @(negedge clock);
        chk("a5_grant", rd_req_ready, 2'b10);
        cyc(); idle();
        @(negedge clock);
        chk("a5_resp_valid", rd_resp_valid, 2'b10);
        chk("a5_resp_data", rd_resp_data, 64'hA5);
        cyc();

        // same-cycle collision, then a non-colliding read of an unwritten address
        wr_req_valid = 2'b01; wr_req_addr[0 +: AW] = 6'd7; wr_req_data[0 +: DW] = 64'h1234;
        rd_req_valid = 2'b01; rd_req_addr[0 +: AW] = 6'd7;
        cyc();
        wr_req_data[0 +: DW] = 64'h5678; rd_req_addr[0 +: AW] = 6'd8;
        @(negedge clock);
        chk("bypass_data", rd_resp_data, 64'h1234);
        cyc(); idle();
        @(negedge clock);
        chk("addr8_data", rd_resp_data, 64'h0);
        rd_req_valid = 2'b10; rd_req_addr[AW +: AW] = 6'd40;
        cyc(); idle();
        @(negedge clock);
        chk("unwritten_data", rd_resp_data, 64'h0);
        cyc();

        // continuous contention on both ports
        wr_req_valid = 2'b11; rd_req_valid = 2'b11;
        wr_req_addr = {6'd2, 6'd1}; wr_req_data = {64'h2222, 64'h1111};
        rd_req_addr = {6'd1, 6'd2};
        repeat (8) cyc();

        for (int i = 0; i < 40; i++) begin
            wr_req_valid = 2'($urandom_range(0, 3));
            rd_req_valid = 2'($urandom_range(0, 3));
            wr_req_addr  = 12'($urandom);
            rd_req_addr  = 12'($urandom_range(0, 4095)) & 12'b000111_000111;
            wr_req_data  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        idle(); cyc();

        // reset on the read-grant cycle drops the response
        rd_req_valid = 2'b01; rd_req_addr[0 +: AW] = 6'd5; reset = 1'b0;
        cyc(); idle();
        @(negedge clock);
        chk("rst_resp_dropped", rd_resp_valid, 2'b00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_sweep_addr", ram_waddr, 6'd0);
        cyc(); reset = 1'b1;
        wait_init();
        wr_req_valid = 2'b11; rd_req_valid = 2'b11;
        @(negedge clock);
        chk("post_rst_wr_grant", wr_req_ready, 2'b01);
        chk("post_rst_rd_grant", rd_req_ready, 2'b01);
        repeat (4) cyc();
        idle(); repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
